// File: rtl/digital_clock_ctrl_if.sv
// Bundles the button, time-source and display/load signals of digital_clock_ctrl.
// master = environment (buttons + datapath), slave = the controller.
interface digital_clock_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       sec_pulse;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       load_en;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic [1:0] edit_field;
  logic       blink;
  logic [4:0] disp_hours;
  logic [5:0] disp_minutes;
  logic       alarm_ring;

  modport master (
    output btn_mode, btn_inc, sec_pulse, cur_hours, cur_minutes,
    input  load_en, load_hours, load_minutes, load_seconds,
    input  edit_field, blink, disp_hours, disp_minutes, alarm_ring
  );

  modport slave (
    input  btn_mode, btn_inc, sec_pulse, cur_hours, cur_minutes,
    output load_en, load_hours, load_minutes, load_seconds,
    output edit_field, blink, disp_hours, disp_minutes, alarm_ring
  );
endinterface

// File: rtl/digital_clock_ctrl.sv
// Time-setting controller for a digital clock: mode/inc buttons, edit timeout, blink, load strobe.
// Optional alarm setting and ringing is built when DIGITAL_CLOCK_CTRL_ALARM_EN is defined.
module digital_clock_ctrl #(
  parameter int MAX_HOURS   = 23,
  parameter int MAX_MINUTES = 59,
  parameter int TIMEOUT_S   = 10
) (
  input logic clk,
  input logic reset,
  digital_clock_ctrl_if.slave bus
);

  localparam logic [2:0] RUN     = 3'd0;
  localparam logic [2:0] SET_HR  = 3'd1;
  localparam logic [2:0] SET_MIN = 3'd2;
  localparam logic [2:0] COMMIT  = 3'd3;
`ifdef DIGITAL_CLOCK_CTRL_ALARM_EN
  localparam logic [2:0] ALARM_HR  = 3'd4;
  localparam logic [2:0] ALARM_MIN = 3'd5;
`endif

  localparam logic [4:0] HOUR_LAST = 5'(MAX_HOURS);
  localparam logic [5:0] MIN_LAST  = 6'(MAX_MINUTES);
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_S - 1);

  logic [2:0] state;
  logic [2:0] state_next;
  logic       mode_prev;
  logic       inc_prev;
  logic       mode_edge;
  logic       inc_edge;
  logic       inc_only;
  logic       any_edge;
  logic       in_edit;
  logic       next_in_edit;
  logic [7:0] idle_cnt;
  logic [4:0] edit_hours;
  logic [5:0] edit_minutes;

  assign mode_edge = bus.btn_mode & ~mode_prev;
  assign inc_edge  = bus.btn_inc & ~inc_prev;
  assign inc_only  = inc_edge & ~mode_edge;
  assign any_edge  = mode_edge | inc_edge;

`ifdef DIGITAL_CLOCK_CTRL_ALARM_EN
  assign in_edit      = (state == SET_HR) || (state == SET_MIN) ||
                        (state == ALARM_HR) || (state == ALARM_MIN);
  assign next_in_edit = (state_next == SET_HR) || (state_next == SET_MIN) ||
                        (state_next == ALARM_HR) || (state_next == ALARM_MIN);
`else
  assign in_edit      = (state == SET_HR) || (state == SET_MIN);
  assign next_in_edit = (state_next == SET_HR) || (state_next == SET_MIN);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
    end else begin
      mode_prev <= bus.btn_mode;
      inc_prev  <= bus.btn_inc;
    end
  end

  // Mode edge always advances; idle timeout in an edit state overrides back to RUN.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (mode_edge) state_next = SET_HR;
      SET_HR:  if (mode_edge) state_next = SET_MIN;
      SET_MIN: if (mode_edge) state_next = COMMIT;
`ifdef DIGITAL_CLOCK_CTRL_ALARM_EN
      COMMIT:    state_next = ALARM_HR;
      ALARM_HR:  if (mode_edge) state_next = ALARM_MIN;
      ALARM_MIN: if (mode_edge) state_next = RUN;
`else
      COMMIT:    state_next = RUN;
`endif
      default:   state_next = RUN;
    endcase
    if (in_edit && !any_edge && bus.sec_pulse && (idle_cnt >= IDLE_LAST))
      state_next = RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= 8'd0;
    end else if (!in_edit || any_edge) begin
      idle_cnt <= 8'd0;
    end else if (bus.sec_pulse) begin
      idle_cnt <= (idle_cnt >= IDLE_LAST) ? 8'd0 : idle_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edit_hours   <= 5'd0;
      edit_minutes <= 6'd0;
    end else if ((state == RUN) && mode_edge) begin
      edit_hours   <= bus.cur_hours;
      edit_minutes <= bus.cur_minutes;
    end else if ((state == SET_HR) && inc_only) begin
      edit_hours <= (edit_hours >= HOUR_LAST) ? 5'd0 : edit_hours + 5'd1;
    end else if ((state == SET_MIN) && inc_only) begin
      edit_minutes <= (edit_minutes >= MIN_LAST) ? 6'd0 : edit_minutes + 6'd1;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.load_en      <= 1'b0;
      bus.load_hours   <= 5'd0;
      bus.load_minutes <= 6'd0;
      bus.load_seconds <= 6'd0;
      bus.edit_field   <= 2'd0;
      bus.blink        <= 1'b0;
    end else begin
      bus.load_en      <= (state_next == COMMIT);
      bus.load_hours   <= (state_next == COMMIT) ? edit_hours : 5'd0;
      bus.load_minutes <= (state_next == COMMIT) ? edit_minutes : 6'd0;
      bus.load_seconds <= 6'd0;
      case (state_next)
        SET_HR:    bus.edit_field <= 2'd1;
        SET_MIN:   bus.edit_field <= 2'd2;
`ifdef DIGITAL_CLOCK_CTRL_ALARM_EN
        ALARM_HR:  bus.edit_field <= 2'd1;
        ALARM_MIN: bus.edit_field <= 2'd2;
`endif
        default:   bus.edit_field <= 2'd0;
      endcase
      if ((state_next != state) || !next_in_edit)
        bus.blink <= 1'b0;
      else if (bus.sec_pulse)
        bus.blink <= ~bus.blink;
    end
  end

`ifdef DIGITAL_CLOCK_CTRL_ALARM_EN
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       armed;
  logic       ring_ack;
  logic       alarm_match;

  assign alarm_match = armed && (bus.cur_hours == alarm_hours) &&
                       (bus.cur_minutes == alarm_minutes);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_hours   <= 5'd0;
      alarm_minutes <= 6'd0;
      armed         <= 1'b0;
    end else begin
      if ((state == ALARM_HR) && inc_only)
        alarm_hours <= (alarm_hours >= HOUR_LAST) ? 5'd0 : alarm_hours + 5'd1;
      if ((state == ALARM_MIN) && inc_only)
        alarm_minutes <= (alarm_minutes >= MIN_LAST) ? 6'd0 : alarm_minutes + 6'd1;
      if ((state == ALARM_MIN) && mode_edge)
        armed <= 1'b1;
    end
  end

  // ring_ack remembers a silenced ring so it stays quiet for the rest of the matching minute.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.alarm_ring <= 1'b0;
      ring_ack       <= 1'b0;
    end else begin
      if (!alarm_match)
        ring_ack <= 1'b0;
      else if ((state == RUN) && inc_edge)
        ring_ack <= 1'b1;
      if ((state != RUN) || !alarm_match || inc_edge)
        bus.alarm_ring <= 1'b0;
      else if (!ring_ack)
        bus.alarm_ring <= 1'b1;
    end
  end
`else
  assign bus.alarm_ring = 1'b0;
`endif

  always_comb begin
    bus.disp_hours   = bus.cur_hours;
    bus.disp_minutes = bus.cur_minutes;
    case (state)
      SET_HR, SET_MIN: begin
        bus.disp_hours   = edit_hours;
        bus.disp_minutes = edit_minutes;
      end
`ifdef DIGITAL_CLOCK_CTRL_ALARM_EN
      ALARM_HR, ALARM_MIN: begin
        bus.disp_hours   = alarm_hours;
        bus.disp_minutes = alarm_minutes;
      end
`endif
      default: begin
        bus.disp_hours   = bus.cur_hours;
        bus.disp_minutes = bus.cur_minutes;
      end
    endcase
  end

endmodule

// File: tb/tb_digital_clock_ctrl.sv
// Self-checking bench for digital_clock_ctrl; load strobes are checked against a scoreboard queue.
// Alarm scenario is compiled only when DIGITAL_CLOCK_CTRL_ALARM_EN is defined.
module tb_digital_clock_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [16:0] sb[$];

  digital_clock_ctrl_if bus();

  digital_clock_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive button/pulse levels for a number of cycles, then release everything for one cycle.
  task automatic applyStimulus(input logic mode, input logic inc, input logic sec, input int cycles);
    bus.btn_mode  = mode;
    bus.btn_inc   = inc;
    bus.sec_pulse = sec;
    repeat (cycles) tick();
    bus.btn_mode  = 1'b0;
    bus.btn_inc   = 1'b0;
    bus.sec_pulse = 1'b0;
    tick();
  endtask

  // Every load strobe must match the oldest queued expectation; idle cycles must carry zeros.
  always @(negedge clk) begin
    if (bus.load_en) begin
      if (sb.size() == 0)
        checkOutput("load_unexpected", 32'd1, 32'd0);
      else
        checkOutput("load_value", {15'd0, bus.load_hours, bus.load_minutes, bus.load_seconds},
                    {15'd0, sb.pop_front()});
    end else begin
      checkOutput("load_idle_zero", {15'd0, bus.load_hours, bus.load_minutes, bus.load_seconds}, 32'd0);
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.btn_mode  = 1'b0;
    bus.btn_inc   = 1'b0;
    bus.sec_pulse = 1'b0;
    bus.cur_hours   = 5'd12;
    bus.cur_minutes = 6'd34;
    repeat (2) tick();
    checkOutput("rst_edit_field", 32'(bus.edit_field), 32'd0);
    checkOutput("rst_blink", 32'(bus.blink), 32'd0);
    checkOutput("rst_load_en", 32'(bus.load_en), 32'd0);
    checkOutput("rst_alarm_ring", 32'(bus.alarm_ring), 32'd0);
    checkOutput("rst_disp_hours", 32'(bus.disp_hours), 32'd12);
    checkOutput("rst_disp_minutes", 32'(bus.disp_minutes), 32'd34);
    reset = 1'b0;
    tick();

    // Enter SET_HR, hours wrap from 23 to 0 after twelve increments.
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("sethr_field", 32'(bus.edit_field), 32'd1);
    checkOutput("sethr_disp_h", 32'(bus.disp_hours), 32'd12);
    checkOutput("sethr_disp_m", 32'(bus.disp_minutes), 32'd34);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("hour_wrap", 32'(bus.disp_hours), 32'd0);

`ifndef DIGITAL_CLOCK_CTRL_ALARM_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("setmin_field", 32'(bus.edit_field), 32'd2);
    checkOutput("setmin_disp_m", 32'(bus.disp_minutes), 32'd34);
    sb.push_back({5'd0, 6'd34, 6'd0});
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("commit1_drained", 32'(sb.size()), 32'd0);
    checkOutput("commit1_field", 32'(bus.edit_field), 32'd0);

    // Minute wrap 59 -> 0 then commit 07:00:00.
    bus.cur_hours   = 5'd7;
    bus.cur_minutes = 6'd58;
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("min_59", 32'(bus.disp_minutes), 32'd59);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("min_wrap", 32'(bus.disp_minutes), 32'd0);
    sb.push_back({5'd7, 6'd0, 6'd0});
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("commit2_drained", 32'(sb.size()), 32'd0);
    checkOutput("commit2_field", 32'(bus.edit_field), 32'd0);
    checkOutput("commit2_disp_h", 32'(bus.disp_hours), 32'd7);

    // Idle timeout: ten seconds without buttons abandons the edit, blink toggles meanwhile.
    bus.cur_hours   = 5'd3;
    bus.cur_minutes = 6'd3;
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("entry_blink", 32'(bus.blink), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      if (k < 10) begin
        checkOutput("timeout_field", 32'(bus.edit_field), 32'd1);
        checkOutput("blink_phase", 32'(bus.blink), 32'(k % 2));
      end
    end
    checkOutput("timeout_run", 32'(bus.edit_field), 32'd0);
    checkOutput("timeout_blink", 32'(bus.blink), 32'd0);
    checkOutput("timeout_disp_h", 32'(bus.disp_hours), 32'd3);

    // Held inc gives one step; simultaneous mode+inc advances without incrementing.
    bus.cur_hours   = 5'd5;
    bus.cur_minutes = 6'd10;
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 5);
    checkOutput("held_inc", 32'(bus.disp_hours), 32'd6);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("both_field", 32'(bus.edit_field), 32'd2);
    checkOutput("both_hours", 32'(bus.disp_hours), 32'd6);
    checkOutput("both_minutes", 32'(bus.disp_minutes), 32'd10);
    sb.push_back({5'd6, 6'd10, 6'd0});
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("commit3_drained", 32'(sb.size()), 32'd0);

    // Reset in SET_MIN abandons the edit with no load afterwards.
    bus.cur_hours   = 5'd9;
    bus.cur_minutes = 6'd15;
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("pre_rst_field", 32'(bus.edit_field), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("midrst_field", 32'(bus.edit_field), 32'd0);
    checkOutput("midrst_disp_h", 32'(bus.disp_hours), 32'd9);
    checkOutput("midrst_load", 32'(bus.load_en), 32'd0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    checkOutput("post_rst_field", 32'(bus.edit_field), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("post_rst_sethr", 32'(bus.edit_field), 32'd1);
`else
    // Commit 00:34, then set alarm 06:30 and arm it.
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    sb.push_back({5'd0, 6'd34, 6'd0});
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("alm_commit_drained", 32'(sb.size()), 32'd0);
    checkOutput("alm_hr_field", 32'(bus.edit_field), 32'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("alm_hr_disp", 32'(bus.disp_hours), 32'd6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("alm_min_disp", 32'(bus.disp_minutes), 32'd30);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("alm_run_field", 32'(bus.edit_field), 32'd0);
    bus.cur_hours   = 5'd6;
    bus.cur_minutes = 6'd29;
    tick();
    checkOutput("ring_before", 32'(bus.alarm_ring), 32'd0);
    bus.cur_minutes = 6'd30;
    tick();
    checkOutput("ring_set", 32'(bus.alarm_ring), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("ring_cleared", 32'(bus.alarm_ring), 32'd0);
    repeat (3) tick();
    checkOutput("ring_stays_off", 32'(bus.alarm_ring), 32'd0);
    bus.cur_minutes = 6'd31;
    tick();
    checkOutput("ring_next_min", 32'(bus.alarm_ring), 32'd0);
`endif

    repeat (3) tick();
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/digital_clock_ctrl.md
DIGITAL_CLOCK_CTRL -- requirements
Module: digital_clock_ctrl

Interface
REQ-001 MAX_HOURS, 23, hour wrap limit for edited/alarm hours.
REQ-002 MAX_MINUTES, 59, minute wrap limit for edited/alarm minutes.
REQ-003 TIMEOUT_S, 10, seconds of button inactivity before an edit is abandoned.
REQ-004 Clocking SHALL be: reset reset, asynchronous, active-high; clock clk.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 btn_mode  in  1  mode button level, already synchronized to clk.
REQ-008 btn_inc  in  1  increment button level, already synchronized to clk.
REQ-009 sec_pulse  in  1  one-clk pulse per second from the clock datapath.
REQ-010 cur_hours  in  5  current hours, binary 0..23.
REQ-011 cur_minutes  in  6  current minutes, binary 0..59.
REQ-012 load_en  out  1  one-clk strobe loading new time into the datapath.
REQ-013 load_hours / load_minutes / load_seconds  out  5/6/6  values valid while load_en=1.
REQ-014 edit_field  out  2  0=none, 1=hours, 2=minutes being edited.
REQ-015 blink  out  1  display-blank phase for the edited field.
REQ-016 disp_hours / disp_minutes  out  5/6  time to be shown on the display.
REQ-017 alarm_ring  out  1  alarm active (ALARM_EN builds only; tied 0 otherwise).

Function
REQ-018 Button presses SHALL be detected on rising edges only (registered previous level); a held button SHALL produce one event.
REQ-019 States SHALL be RUN, SET_HR, SET_MIN, COMMIT, plus ALARM_HR, ALARM_MIN when ALARM_EN is defined.
REQ-020 RUN + mode edge -> SET_HR; edit_hours/edit_minutes SHALL capture cur_hours/cur_minutes on that same edge.
REQ-021 SET_HR + mode edge -> SET_MIN; SET_MIN + mode edge -> COMMIT.
REQ-022 In SET_HR, an inc edge SHALL increment edit_hours, wrapping MAX_HOURS -> 0; in SET_MIN, edit_minutes wraps MAX_MINUTES -> 0.
REQ-023 COMMIT SHALL last exactly one clk, assert load_en=1 with load_hours=edit_hours, load_minutes=edit_minutes, load_seconds=0, then go to RUN (ALARM_HR if ALARM_EN).
REQ-024 load_en SHALL be 0 in every other state and cycle; load_* SHALL be 0 when load_en=0.
REQ-025 Mode and inc edges in the same cycle: mode SHALL win, inc SHALL be discarded.
REQ-026 An idle counter SHALL clear on any button edge and increment on sec_pulse in SET_HR/SET_MIN/ALARM_HR/ALARM_MIN; on reaching TIMEOUT_S it SHALL force RUN with no load_en and alarm settings unchanged.
REQ-027 blink SHALL toggle on each sec_pulse in any edit state, be forced 0 on every state entry and in RUN/COMMIT.
REQ-028 edit_field SHALL be 1 in SET_HR/ALARM_HR, 2 in SET_MIN/ALARM_MIN, 0 otherwise.
REQ-029 disp_* SHALL be cur_* in RUN/COMMIT, edit_* in SET_HR/SET_MIN, alarm_* in ALARM_HR/ALARM_MIN.
REQ-030 All outputs except disp_* SHALL be registered; disp_* is a combinational mux of registered sources.

Reset
REQ-031 Reset SHALL force RUN, edit/alarm registers 0, idle counter 0, button history 0, alarm disarmed, all outputs 0 except disp_* = cur_*.
REQ-032 Reset asserted mid-edit SHALL abandon the edit; no load_en SHALL be produced by or after it.

Configuration
REQ-033 Macro DIGITAL_CLOCK_CTRL_ALARM_EN: defined -> alarm states, alarm_hours/alarm_minutes registers, armed flag and alarm_ring present; undefined -> COMMIT returns to RUN and alarm_ring is constant 0.
REQ-034 With alarm: ALARM_HR/ALARM_MIN edit alarm_* as REQ-022; mode edge in ALARM_MIN -> RUN and sets armed=1.
REQ-035 With alarm: alarm_ring SHALL set in RUN on the first cycle cur_hours/cur_minutes equal alarm_* while armed; it SHALL clear on an inc edge in RUN or when the match ends; an inc edge that clears the ring SHALL NOT re-set it within the same matching minute.

Verification
REQ-036 Reset, cur=12:34, mode edge -> edit_field=1, disp=12:34; inc x12 -> disp_hours=0 (wrap from 23).
REQ-037 From SET_MIN with edit=07:59, inc -> edit_minutes=0; mode -> exactly one clk load_en=1, load=07:00:00, then state RUN (non-alarm build).
REQ-038 Enter SET_HR, no buttons, 10 sec_pulses -> RUN, load_en never asserted, edit_field=0.
REQ-039 Mode and inc rising in same cycle in SET_HR -> state SET_MIN, edit_hours unchanged.
REQ-040 ALARM_EN: set alarm 06:30, cur goes 06:29->06:30 -> alarm_ring=1 next clk; inc edge -> 0 and stays 0 until cur=06:31.
REQ-041 Reset asserted during SET_MIN -> outputs at reset values next clk, no load_en after deassert.
